// File: rtl/gpmc_misc_master.sv
// gpmc_misc_master: GPMC chip-select-3 bus initiator.
// Turns a single valid/ready command into a CS / WE / OE cycle on the 8-bit
// GPMC bus. Each access runs SETUP -> STROBE -> HOLD. Reads add a TURN phase
// so the slave can release the bus.
// Ports:
//   fpga_clk, sys_reset_n           clock, async active-low reset
//   req_valid/req_ready             command handshake (accept on valid&&ready)
//   req_wr, req_addr, req_wdata     command payload
//   rsp_valid, rsp_rdata            one-cycle completion pulse, read data
//   gpmc_cs3_n/we_n/oe_n, sa, sd    GPMC bus (sd driven only for writes)
module gpmc_misc_master #(
  parameter int unsigned SA_WIDTH   = 8,
  parameter int unsigned SD_WIDTH   = 8,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned TURN_CYC   = 1
) (
  input  logic                fpga_clk,
  input  logic                sys_reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [SA_WIDTH-1:0] req_addr,
  input  logic [SD_WIDTH-1:0] req_wdata,
  output logic                rsp_valid,
  output logic [SD_WIDTH-1:0] rsp_rdata,
  output logic                gpmc_cs3_n,
  output logic                gpmc_we_n,
  output logic                gpmc_oe_n,
  output logic [SA_WIDTH-1:0] sa,
  inout  wire  [SD_WIDTH-1:0] sd
);

  // Phase counter sized for the longest phase; it holds (length - 1).
  localparam int unsigned MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CD  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_TURN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [SA_WIDTH-1:0] sa_q, sa_d;
  logic [SD_WIDTH-1:0] wdata_q, wdata_d;
  logic                sd_oe_q, sd_oe_d;
  logic                cs_n_q, cs_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [SD_WIDTH-1:0] rdata_q, rdata_d;

  logic cnt_done;
  assign cnt_done = (cnt_q == '0);

  // Next-state and next-output logic; every bus output is a flop fed from here.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    sa_d        = sa_q;
    wdata_d     = wdata_q;
    sd_oe_d     = sd_oe_q;
    cs_n_d      = cs_n_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          wr_d    = req_wr;
          sa_d    = req_addr;
          wdata_d = req_wdata;
          sd_oe_d = req_wr;
          cs_n_d  = 1'b0;
          ready_d = 1'b0;
          cnt_d   = SETUP_LD;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_done) begin
          we_n_d  = ~wr_q;
          oe_n_d  = wr_q;
          cnt_d   = STROBE_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STROBE: begin
        if (cnt_done) begin
          // Last edge with OE low: capture the slave's data here.
          if (!wr_q) rdata_d = sd;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          cs_n_d      = 1'b1;
          sd_oe_d     = 1'b0;
          rsp_valid_d = 1'b1;
          if (wr_q) begin
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = TURN_LD;
            state_d = S_TURN;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_TURN: begin
        if (cnt_done) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        sd_oe_d = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge fpga_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      sa_q        <= '0;
      wdata_q     <= '0;
      sd_oe_q     <= 1'b0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      sa_q        <= sa_d;
      wdata_q     <= wdata_d;
      sd_oe_q     <= sd_oe_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign gpmc_cs3_n = cs_n_q;
  assign gpmc_we_n  = we_n_q;
  assign gpmc_oe_n  = oe_n_q;
  assign sa         = sa_q;
  assign sd         = sd_oe_q ? wdata_q : {SD_WIDTH{1'bz}};

endmodule

// File: tb/tb_gpmc_misc_master.sv
// tb_gpmc_misc_master: directed bench for gpmc_misc_master.
// dut0 uses default timing (2/4/2/1), dut1 uses 1/1/1/1. Each has a simple
// register-bank slave; the data buses are pulled up so an undriven bus reads 0xFF.
module tb_gpmc_misc_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // dut0 signals
  logic       req_valid0, req_ready0, req_wr0, rsp_valid0;
  logic [7:0] req_addr0, req_wdata0, rsp_rdata0, sa0;
  logic       cs0, we0, oe0;
  tri1  [7:0] sd0;
  // dut1 signals
  logic       req_valid1, req_ready1, req_wr1, rsp_valid1;
  logic [7:0] req_addr1, req_wdata1, rsp_rdata1, sa1;
  logic       cs1, we1, oe1;
  tri1  [7:0] sd1;

  gpmc_misc_master u_dut0 (
    .fpga_clk(clk), .sys_reset_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_wr(req_wr0),
    .req_addr(req_addr0), .req_wdata(req_wdata0),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
    .gpmc_cs3_n(cs0), .gpmc_we_n(we0), .gpmc_oe_n(oe0), .sa(sa0), .sd(sd0)
  );

  gpmc_misc_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(1)) u_dut1 (
    .fpga_clk(clk), .sys_reset_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
    .gpmc_cs3_n(cs1), .gpmc_we_n(we1), .gpmc_oe_n(oe1), .sa(sa1), .sd(sd1)
  );

  // Slave register banks: drive on OE, capture while WE is low.
  logic [7:0] mem0 [0:255];
  logic [7:0] mem1 [0:255];
  assign sd0 = (!cs0 && !oe0) ? mem0[sa0] : 8'bz;
  assign sd1 = (!cs1 && !oe1) ? mem1[sa1] : 8'bz;
  always @(posedge clk) if (!cs0 && !we0) mem0[sa0] <= sd0;
  always @(posedge clk) if (!cs1 && !we1) mem1[sa1] <= sd1;

  // Protocol violations: both strobes low, or a strobe low with CS high.
  int viol0 = 0, viol1 = 0;
  always @(negedge clk) begin
    if ((!we0 && !oe0) || ((!we0 || !oe0) && cs0)) viol0++;
    if ((!we1 && !oe1) || ((!we1 || !oe1) && cs1)) viol1++;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Per-cycle samples; index i is the cycle starting at accept edge k+i.
  logic       s_cs [0:15], s_we [0:15], s_oe [0:15], s_rv [0:15], s_rdy [0:15];
  logic [7:0] s_sa [0:15], s_sd [0:15], s_rd [0:15];

  int a_cs_cnt, a_cs_first, a_cs_last, a_stb_cnt, a_stb_first, a_stb_last;
  int a_ostb_cnt, a_rv_cnt, a_rv_idx, a_rv_data, a_sa_bad, a_sd_bad;

  // Waits for ready, presents one command, returns at the negedge after the accept edge.
  task automatic start_access(input bit sel, input bit wr, input logic [7:0] a, input logic [7:0] d);
    int t;
    t = 0;
    @(negedge clk);
    while (!(sel ? req_ready1 : req_ready0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("ready_wait", t, 0);
    if (sel) begin
      req_valid1 = 1'b1; req_wr1 = wr; req_addr1 = a; req_wdata1 = d;
    end else begin
      req_valid0 = 1'b1; req_wr0 = wr; req_addr0 = a; req_wdata0 = d;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid0 = 1'b0;
    req_valid1 = 1'b0;
  endtask

  task automatic sample_n(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      s_cs[i]  = sel ? cs1 : cs0;
      s_we[i]  = sel ? we1 : we0;
      s_oe[i]  = sel ? oe1 : oe0;
      s_rv[i]  = sel ? rsp_valid1 : rsp_valid0;
      s_rdy[i] = sel ? req_ready1 : req_ready0;
      s_sa[i]  = sel ? sa1 : sa0;
      s_sd[i]  = sel ? sd1 : sd0;
      s_rd[i]  = sel ? rsp_rdata1 : rsp_rdata0;
    end
  endtask

  task automatic analyze(input int n, input bit wr, input logic [7:0] a, input logic [7:0] d);
    logic stb, ostb;
    a_cs_cnt = 0; a_cs_first = -1; a_cs_last = -1;
    a_stb_cnt = 0; a_stb_first = -1; a_stb_last = -1;
    a_ostb_cnt = 0; a_rv_cnt = 0; a_rv_idx = -1; a_rv_data = -1;
    a_sa_bad = 0; a_sd_bad = 0;
    for (int i = 0; i < n; i++) begin
      stb  = wr ? s_we[i] : s_oe[i];
      ostb = wr ? s_oe[i] : s_we[i];
      if (!s_cs[i]) begin
        a_cs_cnt++;
        if (a_cs_first < 0) a_cs_first = i;
        a_cs_last = i;
        if (s_sa[i] != a) a_sa_bad++;
      end
      if (!stb) begin
        a_stb_cnt++;
        if (a_stb_first < 0) a_stb_first = i;
        a_stb_last = i;
      end
      if (!ostb) a_ostb_cnt++;
      if (s_rv[i]) begin
        a_rv_cnt++;
        a_rv_idx = i;
        a_rv_data = int'(s_rd[i]);
      end
      if (wr) begin
        if (s_sd[i] != (!s_cs[i] ? d : 8'hFF)) a_sd_bad++;
      end else if (s_cs[i] || s_oe[i]) begin
        if (s_sd[i] != 8'hFF) a_sd_bad++;
      end
    end
  endtask

  int n_acc, hr, ngap, acc_seen, rv_seen, b2b_rd;
  int gaps [0:3];
  logic prev_cs, will_acc;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[8'h03] = 8'hA5;
    mem0[8'h09] = 8'h55;
    mem1[8'h03] = 8'h3C;
    {req_valid0, req_wr0, req_addr0, req_wdata0} = '0;
    {req_valid1, req_wr1, req_addr1, req_wdata1} = '0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cs", cs0, 1);
    chk("rst_we", we0, 1);
    chk("rst_oe", oe0, 1);
    chk("rst_sd_z", sd0, 8'hFF);
    chk("rst_sa", sa0, 0);
    chk("rst_ready", req_ready0, 1);
    chk("rst_rsp_valid", rsp_valid0, 0);
    chk("rst_rdata", rsp_rdata0, 0);

    // Single write 0x06 <= 0x05
    start_access(1'b0, 1'b1, 8'h06, 8'h05);
    sample_n(1'b0, 12);
    analyze(12, 1'b1, 8'h06, 8'h05);
    chk("wr_cs_cnt", a_cs_cnt, 8);
    chk("wr_cs_first", a_cs_first, 0);
    chk("wr_cs_last", a_cs_last, 7);
    chk("wr_we_first", a_stb_first, 2);
    chk("wr_we_last", a_stb_last, 5);
    chk("wr_we_cnt", a_stb_cnt, 4);
    chk("wr_oe_cnt", a_ostb_cnt, 0);
    chk("wr_sa_stable", a_sa_bad, 0);
    chk("wr_sd_stable", a_sd_bad, 0);
    chk("wr_rv_cnt", a_rv_cnt, 1);
    chk("wr_rv_idx", a_rv_idx, 8);
    chk("wr_ready7", s_rdy[7], 0);
    chk("wr_ready8", s_rdy[8], 1);
    chk("wr_slave_mem", mem0[8'h06], 8'h05);

    // Single read 0x03 -> 0xA5
    start_access(1'b0, 1'b0, 8'h03, 8'h00);
    sample_n(1'b0, 12);
    analyze(12, 1'b0, 8'h03, 8'h00);
    chk("rd_cs_cnt", a_cs_cnt, 8);
    chk("rd_oe_first", a_stb_first, 2);
    chk("rd_oe_last", a_stb_last, 5);
    chk("rd_oe_cnt", a_stb_cnt, 4);
    chk("rd_we_cnt", a_ostb_cnt, 0);
    chk("rd_sa_stable", a_sa_bad, 0);
    chk("rd_sd_undriven", a_sd_bad, 0);
    chk("rd_rv_cnt", a_rv_cnt, 1);
    chk("rd_rv_idx", a_rv_idx, 8);
    chk("rd_rdata", a_rv_data, 8'hA5);
    chk("rd_rdata_held", s_rd[11], 8'hA5);
    chk("rd_ready8", s_rdy[8], 0);
    chk("rd_ready9", s_rdy[9], 1);

    // Back-to-back: write(0x09,0x00), read(0x09), write(0x07,0x03) with valid held
    @(negedge clk);
    req_wr0 = 1'b1; req_addr0 = 8'h09; req_wdata0 = 8'h00; req_valid0 = 1'b1;
    n_acc = 0; hr = 0; ngap = 0; acc_seen = 0; rv_seen = 0; b2b_rd = -1;
    prev_cs = 1'b1;
    for (int c = 0; c < 40; c++) begin
      will_acc = req_ready0 && req_valid0;
      @(negedge clk);
      if (!cs0 && prev_cs) begin
        if (acc_seen > 0 && ngap < 4) begin
          gaps[ngap] = hr;
          ngap++;
        end
        acc_seen++;
      end
      if (cs0) hr++; else hr = 0;
      prev_cs = cs0;
      if (rsp_valid0) begin
        rv_seen++;
        if (rv_seen == 2) b2b_rd = int'(rsp_rdata0);
      end
      if (will_acc) begin
        n_acc++;
        if (n_acc == 1) begin
          req_wr0 = 1'b0; req_addr0 = 8'h09; req_wdata0 = 8'h00;
        end else if (n_acc == 2) begin
          req_wr0 = 1'b1; req_addr0 = 8'h07; req_wdata0 = 8'h03;
        end else begin
          req_valid0 = 1'b0;
        end
      end
    end
    req_valid0 = 1'b0;
    chk("b2b_accesses", acc_seen, 3);
    chk("b2b_rv_cnt", rv_seen, 3);
    chk("b2b_gap_cnt", ngap, 2);
    chk("b2b_gap_after_wr", gaps[0], 1);
    chk("b2b_gap_after_rd", gaps[1], 2);
    chk("b2b_rdata", b2b_rd, 8'h00);
    chk("b2b_mem09", mem0[8'h09], 8'h00);
    chk("b2b_mem07", mem0[8'h07], 8'h03);

    // Reset during the STROBE phase of a write
    start_access(1'b0, 1'b1, 8'h0B, 8'h3C);
    repeat (3) @(negedge clk);
    chk("rstmid_we_low", we0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs", cs0, 1);
    chk("rstmid_we", we0, 1);
    chk("rstmid_sd_z", sd0, 8'hFF);
    chk("rstmid_ready", req_ready0, 1);
    rv_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid0) rv_seen++;
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid0) rv_seen++;
    end
    chk("rstmid_no_rv", rv_seen, 0);
    start_access(1'b0, 1'b1, 8'h0A, 8'h5A);
    sample_n(1'b0, 12);
    analyze(12, 1'b1, 8'h0A, 8'h5A);
    chk("post_rst_cs_cnt", a_cs_cnt, 8);
    chk("post_rst_rv_idx", a_rv_idx, 8);
    chk("post_rst_mem", mem0[8'h0A], 8'h5A);

    // Single-cycle phases (dut1)
    start_access(1'b1, 1'b0, 8'h03, 8'h00);
    sample_n(1'b1, 8);
    analyze(8, 1'b0, 8'h03, 8'h00);
    chk("p1_rd_cs_cnt", a_cs_cnt, 3);
    chk("p1_rd_oe_first", a_stb_first, 1);
    chk("p1_rd_oe_cnt", a_stb_cnt, 1);
    chk("p1_rd_rv_idx", a_rv_idx, 3);
    chk("p1_rd_rdata", a_rv_data, 8'h3C);
    chk("p1_rd_ready3", s_rdy[3], 0);
    chk("p1_rd_ready4", s_rdy[4], 1);
    start_access(1'b1, 1'b1, 8'h11, 8'h77);
    sample_n(1'b1, 8);
    analyze(8, 1'b1, 8'h11, 8'h77);
    chk("p1_wr_cs_cnt", a_cs_cnt, 3);
    chk("p1_wr_we_first", a_stb_first, 1);
    chk("p1_wr_rv_idx", a_rv_idx, 3);
    chk("p1_wr_sd", a_sd_bad, 0);
    chk("p1_wr_mem", mem1[8'h11], 8'h77);

    chk("strobe_viol_dut0", viol0, 0);
    chk("strobe_viol_dut1", viol1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
